mem_burst_ctrl: RTL and testbench

Initiator-side controller for the team's pseudo-two-port `memory` block (zero-cycle read port, posedge write port). It accepts burst commands (direction, start address, length) and drives the memory's read or write port one word per cycle. Read bursts are streamed out over a valid/ready interface; write bursts are fed in over a valid/ready interface. `mem_read_en` and `mem_write_en` are asserted only for real transfers, because each assertion is charged as energy. It sits between compute/datapath logic and any `memory` instance, internal or external.

---
 rtl/mem_burst_pkg.sv | 11 +
 rtl/mem_burst_ctrl.sv | 113 +++++++++++
 tb/tb_mem_burst_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types for the burst controller that fronts a pseudo-two-port memory.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mem_burst_state_t;

endpackage

// File: rtl/mem_burst_ctrl.sv
// Burst controller: streams a read or write burst through a memory, one word per cycle.
// Latency: first read word valid 2 cycles after accept, first write slot 1 cycle after accept.
// Backpressure: rd_ready low holds the output word and stalls reads; wr_valid low stalls writes.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int HEIGHT = 128,
    localparam int AW     = $clog2(HEIGHT),
    localparam int LW     = $clog2(HEIGHT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LW-1:0]    cmd_len,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [AW-1:0]    mem_read_addr,
    output logic             mem_read_en,
    input  logic [WIDTH-1:0] mem_qout,
    output logic [AW-1:0]    mem_write_addr,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_din,
    output logic             busy,
    output logic             done
);

    mem_burst_state_t state, state_nxt;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    addr_inc;
    logic [LW-1:0]    remaining;
    logic             rem_nz;
    logic             issue;
    logic             wr_xfer;
    logic             out_free;

    assign rem_nz   = (remaining != '0);
    // Explicit wrap so non-power-of-2 depths never address past the last word.
    assign addr_inc = (addr == AW'(HEIGHT - 1)) ? '0 : addr + AW'(1);
    assign out_free = !rd_valid || rd_ready;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0)
                        state_nxt = DONE;
                    else
                        state_nxt = cmd_write ? WRITE : READ;
                end
            end
            READ: begin
                issue = rem_nz && out_free;
                if (!rem_nz && out_free)
                    state_nxt = DONE;
            end
            WRITE: begin
                wr_ready = rem_nz;
                if (!rem_nz || (wr_valid && remaining == LW'(1)))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_xfer        = wr_valid && wr_ready;
    assign mem_read_en    = issue;
    assign mem_read_addr  = issue ? addr : '0;
    assign mem_write_en   = wr_xfer;
    assign mem_write_addr = wr_xfer ? addr : '0;
    assign mem_din        = wr_xfer ? wr_data : '0;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_valid && cmd_ready) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue || wr_xfer) begin
                addr      <= addr_inc;
                remaining <= remaining - LW'(1);
            end
            if (issue) begin
                rd_data  <= mem_qout;
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural pseudo-two-port memory attached.
module tb_mem_burst_ctrl;

    localparam int WIDTH  = 16;
    localparam int HEIGHT = 128;
    localparam int AW     = 7;
    localparam int LW     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [LW-1:0]    cmd_len;
    logic             rd_valid, rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             wr_valid, wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    mem_read_addr, mem_write_addr;
    logic             mem_read_en, mem_write_en;
    logic [WIDTH-1:0] mem_qout, mem_din;
    logic             busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    int rd_en_cnt = 0;
    int wr_en_cnt = 0;
    int rd_snap, wr_snap;
    logic preload = 1'b0;

    logic [WIDTH-1:0] mem [HEIGHT];

    always #5 clk = ~clk;

    mem_burst_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .mem_read_addr(mem_read_addr), .mem_read_en(mem_read_en), .mem_qout(mem_qout),
        .mem_write_addr(mem_write_addr), .mem_write_en(mem_write_en), .mem_din(mem_din),
        .busy(busy), .done(done)
    );

    // Zero-cycle read port, posedge write port.
    assign mem_qout = mem[mem_read_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < HEIGHT; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (mem_write_en) begin
            mem[mem_write_addr] <= mem_din;
        end
        if (mem_read_en)  rd_en_cnt <= rd_en_cnt + 1;
        if (mem_write_en) wr_en_cnt <= wr_en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wrap/back-pressure expectations, one entry per cycle after accept.
    logic        t3_rdy  [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    logic        t3_en   [8] = '{1, 0, 0, 1, 1, 1, 0, 0};
    logic [6:0]  t3_addr [8] = '{126, 0, 0, 127, 0, 1, 0, 0};
    logic        t3_rv   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [15:0] t3_dat  [8] = '{16'h0, 16'h107E, 16'h107E, 16'h107E, 16'h107F, 16'h1000, 16'h1001, 16'h0};
    logic        t3_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst = 1'b1; preload = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        cyc();
        cyc();
        preload = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_en", {mem_read_en, mem_write_en}, 0);
        chk("rst_mem_addr", {mem_read_addr, mem_write_addr}, 0);
        chk("rst_mem_din", mem_din, 0);
        rst = 1'b0;

        // Read burst: addr 5, len 4, rd_ready held high.
        rd_snap = rd_en_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd5; cmd_len = 8'd4; rd_ready = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("rd_c1_busy", busy, 1);
        chk("rd_c1_cmd_ready", cmd_ready, 0);
        chk("rd_c1_en", mem_read_en, 1);
        chk("rd_c1_addr", mem_read_addr, 5);
        chk("rd_c1_valid", rd_valid, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, 32'h1005 + k);
            chk("rd_en", mem_read_en, (k < 3) ? 1 : 0);
            chk("rd_done_early", done, 0);
        end
        cyc();
        #1;
        chk("rd_done", done, 1);
        chk("rd_valid_off", rd_valid, 0);
        chk("rd_en_count", rd_en_cnt - rd_snap, 4);
        cyc();
        #1;
        chk("rd_done_pulse", done, 0);
        chk("rd_idle_ready", cmd_ready, 1);

        // Write burst: addr 10, len 3, wr_valid pattern 1,0,1,1.
        wr_snap = wr_en_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'd10; cmd_len = 8'd3; rd_ready = 1'b0;
        cyc();
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'h00A0;
        #1;
        chk("wr_c1_ready", wr_ready, 1);
        chk("wr_c1_en", mem_write_en, 1);
        chk("wr_c1_addr", mem_write_addr, 10);
        chk("wr_c1_din", mem_din, 16'h00A0);
        cyc();
        wr_valid = 1'b0; wr_data = 16'h00A1;
        #1;
        chk("wr_stall_en", mem_write_en, 0);
        chk("wr_stall_din", mem_din, 0);
        chk("wr_stall_addr", mem_write_addr, 0);
        chk("wr_stall_ready", wr_ready, 1);
        cyc();
        wr_valid = 1'b1;
        #1;
        chk("wr_c3_addr", mem_write_addr, 11);
        cyc();
        wr_data = 16'h00A2;
        #1;
        chk("wr_c4_addr", mem_write_addr, 12);
        chk("wr_c4_din", mem_din, 16'h00A2);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("wr_done", done, 1);
        chk("wr_ready_off", wr_ready, 0);
        chk("wr_mem10", mem[10], 16'h00A0);
        chk("wr_mem11", mem[11], 16'h00A1);
        chk("wr_mem12", mem[12], 16'h00A2);
        chk("wr_en_count", wr_en_cnt - wr_snap, 3);
        cyc();
        #1;
        chk("wr_idle_ready", cmd_ready, 1);

        // Wrap and back-pressure: addr 126, len 4.
        rd_snap = rd_en_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd126; cmd_len = 8'd4;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_ready = t3_rdy[k];
            #1;
            chk("wrap_en", mem_read_en, t3_en[k]);
            chk("wrap_addr", mem_read_addr, t3_addr[k]);
            chk("wrap_valid", rd_valid, t3_rv[k]);
            if (t3_rv[k]) chk("wrap_data", rd_data, t3_dat[k]);
            chk("wrap_done", done, t3_done[k]);
            cyc();
        end
        chk("wrap_en_count", rd_en_cnt - rd_snap, 4);
        rd_ready = 1'b0;

        // Zero-length command.
        rd_snap = rd_en_cnt; wr_snap = wr_en_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd3; cmd_len = 8'd0;
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("len0_done", done, 1);
        chk("len0_cmd_ready", cmd_ready, 0);
        chk("len0_en", {mem_read_en, mem_write_en}, 0);
        cyc();
        #1;
        chk("len0_done_pulse", done, 0);
        chk("len0_idle_ready", cmd_ready, 1);
        chk("len0_rd_count", rd_en_cnt - rd_snap, 0);
        chk("len0_wr_count", wr_en_cnt - wr_snap, 0);

        // Reset after three read words of a len 8 burst.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd20; cmd_len = 8'd8; rd_ready = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        #1;
        chk("rstmid_data", rd_data, 16'h1016);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rd_snap = rd_en_cnt;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", rd_valid, 0);
        chk("rstmid_data_clr", rd_data, 0);
        chk("rstmid_done", done, 0);
        cyc();
        #1;
        chk("rstmid_done2", done, 0);
        chk("rstmid_no_reads", rd_en_cnt - rd_snap, 0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'd40; cmd_len = 8'd1;
        cyc();
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF;
        #1;
        chk("rstmid_wr_en", mem_write_en, 1);
        chk("rstmid_wr_addr", mem_write_addr, 40);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("rstmid_wr_done", done, 1);
        chk("rstmid_wr_mem", mem[40], 16'hBEEF);
        cyc();

        // Back-to-back: write len 2 at 50 then read it back.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'd50; cmd_len = 8'd2;
        cyc();
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'h1111;
        #1;
        chk("b2b_c1_cmd_ready", cmd_ready, 0);
        cyc();
        wr_data = 16'h2222;
        #1;
        chk("b2b_c2_cmd_ready", cmd_ready, 0);
        cyc();
        wr_valid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd50; cmd_len = 8'd2; rd_ready = 1'b1;
        #1;
        chk("b2b_wr_done", done, 1);
        chk("b2b_done_cmd_ready", cmd_ready, 0);
        cyc();
        #1;
        chk("b2b_idle_ready", cmd_ready, 1);
        chk("b2b_idle_busy", busy, 0);
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("b2b_rd_en", mem_read_en, 1);
        chk("b2b_rd_addr", mem_read_addr, 50);
        cyc();
        #1;
        chk("b2b_rd0", rd_data, 16'h1111);
        cyc();
        #1;
        chk("b2b_rd1", rd_data, 16'h2222);
        cyc();
        #1;
        chk("b2b_rd_done", done, 1);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
